// File: rtl/alu_seq.sv
// Multi-cycle ALU responder: valid/ready request in, iterative shift/multiply, held response out.
// Optional restoring divider (DIV/REM opcodes) enabled by defining ALU_SEQ_DIV_EN.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] z,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_NOT = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SLT = 5'b01000;
    localparam logic [4:0] OP_MUL = 5'b01001;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [4:0] OP_DIV = 5'b01010;
    localparam logic [4:0] OP_REM = 5'b01011;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {K_SHL, K_SHR, K_MUL, K_DIV} kind_t;

    state_t           state;
    kind_t            kind;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    cnt;
`ifdef ALU_SEQ_DIV_EN
    logic             is_rem;
`endif

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] quick_z;
    logic             quick_ill;
    logic [WIDTH-1:0] first_shift;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_opa;
    logic [WIDTH-1:0] step_opb;
    logic [WIDTH-1:0] step_z;

    assign sh = y[SHW-1:0];

    // Single-cycle results, computed straight from the request inputs at the accept edge
    always_comb begin
        quick_z   = '0;
        quick_ill = 1'b0;
        case (op)
            OP_ADD:  quick_z = x + y;
            OP_SUB:  quick_z = x - y;
            OP_AND:  quick_z = x & y;
            OP_OR:   quick_z = x | y;
            OP_XOR:  quick_z = x ^ y;
            OP_NOT:  quick_z = ~x;
            OP_SLT:  quick_z = WIDTH'($signed(x) < $signed(y));
            default: quick_ill = 1'b1;
        endcase
    end

    // Shifts perform their first step at accept so sh=1 and sh=0 finish in one cycle
    always_comb begin
        first_shift = x;
        if (sh != '0) begin
            first_shift = (op == OP_SHL) ? (x << 1) : (x >> 1);
        end
    end

    // One iteration of the active multi-cycle operation
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   div_r2;
    logic             div_ge;
    logic [WIDTH:0]   div_rn;

    always_comb begin
        div_r2 = {acc, opa[WIDTH-1]};
        div_ge = (div_r2 >= {1'b0, opb});
        div_rn = div_ge ? (div_r2 - {1'b0, opb}) : div_r2;
    end
`endif

    always_comb begin
        step_acc = acc;
        step_opa = opa;
        step_opb = opb;
        step_z   = '0;
        case (kind)
            K_SHL: begin
                step_acc = acc << 1;
                step_z   = step_acc;
            end
            K_SHR: begin
                step_acc = acc >> 1;
                step_z   = step_acc;
            end
            K_MUL: begin
                step_acc = acc + (opb[0] ? opa : '0);
                step_opa = opa << 1;
                step_opb = opb >> 1;
                step_z   = step_acc;
            end
            default: begin
`ifdef ALU_SEQ_DIV_EN
                step_acc = div_rn[WIDTH-1:0];
                step_opa = {opa[WIDTH-2:0], div_ge};
                step_z   = is_rem ? step_acc : step_opa;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            kind      <= K_SHL;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            z         <= '0;
            illegal   <= 1'b0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            cnt       <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_rem    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        case (op)
                            OP_SHL, OP_SHR: begin
                                kind <= (op == OP_SHL) ? K_SHL : K_SHR;
                                acc  <= first_shift;
                                if (sh <= SHW'(1)) begin
                                    z         <= first_shift;
                                    illegal   <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    cnt   <= CW'(sh) - CW'(1);
                                    state <= BUSY;
                                end
                            end
                            OP_MUL: begin
                                kind  <= K_MUL;
                                acc   <= '0;
                                opa   <= x;
                                opb   <= y;
                                cnt   <= CW'(WIDTH);
                                state <= BUSY;
                            end
`ifdef ALU_SEQ_DIV_EN
                            OP_DIV, OP_REM: begin
                                kind   <= K_DIV;
                                is_rem <= (op == OP_REM);
                                acc    <= '0;
                                opa    <= x;
                                opb    <= y;
                                cnt    <= CW'(WIDTH);
                                state  <= BUSY;
                            end
`endif
                            default: begin
                                z         <= quick_z;
                                illegal   <= quick_ill;
                                rsp_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    acc <= step_acc;
                    opa <= step_opa;
                    opb <= step_opb;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        z         <= step_z;
                        illegal   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random requests checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] z;
    logic         illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .SHW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .z         (z),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results and latency straight from the opcode table
    function automatic void model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] ez, output logic ei, output int el);
        int unsigned s;
        logic [31:0] p;
        s  = 32'(b[3:0]);
        p  = 32'(a) * 32'(b);
        ez = '0;
        ei = 1'b0;
        el = 1;
        case (o)
            5'd0: ez = a + b;
            5'd1: ez = a - b;
            5'd2: ez = a & b;
            5'd3: ez = a | b;
            5'd4: ez = a ^ b;
            5'd5: ez = ~a;
            5'd6: begin ez = a << s; el = (s == 0) ? 1 : int'(s); end
            5'd7: begin ez = a >> s; el = (s == 0) ? 1 : int'(s); end
            5'd8: ez = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            5'd9: begin ez = p[W-1:0]; el = int'(W) + 1; end
`ifdef ALU_SEQ_DIV_EN
            5'd10: begin ez = (b == 0) ? '1 : a / b; el = int'(W) + 1; end
            5'd11: begin ez = (b == 0) ? a : a % b; el = int'(W) + 1; end
`endif
            default: ei = 1'b1;
        endcase
    endfunction

    task automatic send(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!req_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("req_ready before send", 32'(req_ready), 32'd1);
        op = o;
        x = a;
        y = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        op = 5'($urandom);
        x = W'($urandom);
        y = W'($urandom);
    endtask

    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_exp(input string tag, input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ez, input logic ei, input int el);
        int lat;
        send(o, a, b);
        wait_rsp(1, lat);
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " z"}, 32'(z), 32'(ez));
        check({tag, " illegal"}, 32'(illegal), 32'(ei));
        tick();
    endtask

    task automatic run_model(input string tag, input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ez;
        logic ei;
        int el;
        model(o, a, b, ez, ei, el);
        run_exp(tag, o, a, b, ez, ei, el);
    endtask

    initial begin
        int lat;
        logic [4:0] ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        op = '0;
        x = '0;
        y = '0;
        repeat (3) tick();
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset z", 32'(z), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        tick();
        check("post-reset req_ready", 32'(req_ready), 32'd1);

        run_exp("add 5+3", 5'b00000, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1);
        run_exp("add wrap", 5'b00000, 16'hffff, 16'h0001, 16'h0000, 1'b0, 1);
        run_exp("sub", 5'b00001, 16'h0003, 16'h0005, 16'hfffe, 1'b0, 1);
        run_exp("slt signed", 5'b01000, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1);
        run_exp("shl 4", 5'b00110, 16'h0001, 16'h0004, 16'h0010, 1'b0, 4);
        run_exp("shr 0", 5'b00111, 16'hbeef, 16'h0000, 16'hbeef, 1'b0, 1);
        run_exp("shr upper y bits", 5'b00111, 16'h8000, 16'hfff3, 16'h1000, 1'b0, 3);
        run_exp("illegal 1f", 5'b11111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1);

        // MUL with a competing request pulsed while busy
        send(5'b01001, 16'h0123, 16'h0045);
        lat = 1;
        repeat (3) begin
            check("mul busy rsp_valid", 32'(rsp_valid), 32'd0);
            req_valid = 1'b1;
            op = 5'b00000;
            x = 16'h0001;
            y = 16'h0001;
            check("mul busy req_ready", 32'(req_ready), 32'd0);
            tick();
            lat++;
        end
        req_valid = 1'b0;
        wait_rsp(lat, lat);
        check("mul latency", 32'(lat), 32'd17);
        check("mul z", 32'(z), 32'h4e6f);
        check("mul illegal", 32'(illegal), 32'd0);
        tick();
        check("mul no queued rsp", 32'(rsp_valid), 32'd0);
        check("mul back to idle", 32'(req_ready), 32'd1);

        // Back-pressure holds the response
        rsp_ready = 1'b0;
        send(5'b00000, 16'h0001, 16'h0001);
        wait_rsp(1, lat);
        check("bp latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp rsp_valid held", 32'(rsp_valid), 32'd1);
            check("bp z held", 32'(z), 32'h0002);
            check("bp req_ready low", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp released rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp released req_ready", 32'(req_ready), 32'd1);

        // Reset part way through a MUL
        send(5'b01001, 16'h00ff, 16'h00ff);
        repeat (4) tick();
        check("pre-abort rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        tick();
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort z", 32'(z), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("abort recover req_ready", 32'(req_ready), 32'd1);
        run_exp("add after abort", 5'b00000, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1);

`ifdef ALU_SEQ_DIV_EN
        run_exp("div", 5'b01010, 16'h0064, 16'h0007, 16'h000e, 1'b0, 17);
        run_exp("rem", 5'b01011, 16'h0064, 16'h0007, 16'h0002, 1'b0, 17);
        run_exp("div by 0", 5'b01010, 16'h0064, 16'h0000, 16'hffff, 1'b0, 17);
        run_exp("rem by 0", 5'b01011, 16'h0064, 16'h0000, 16'h0064, 1'b0, 17);
`else
        run_exp("div disabled", 5'b01010, 16'h0064, 16'h0007, 16'h0000, 1'b1, 1);
        run_exp("rem disabled", 5'b01011, 16'h0064, 16'h0007, 16'h0000, 1'b1, 1);
`endif

        for (int i = 0; i < 80; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
            run_model($sformatf("rand%0d op%0h", i, ro), ro, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
